// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - state encoding and framing constants shared by the boot image writer
package boot_pkg;

  typedef enum logic [2:0] {HDR, DATA, WRITE, CSUM, DONE, ERR} boot_state_t;

  localparam int HDR_BYTES  = 4;
  localparam int CSUM_BYTES = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - little-endian byte-to-word gatherer with a run-time word width
// The word appears combinationally, together with word_valid, on the cycle its last byte is taken.
module byte_packer #(
  parameter int MAX_BYTES = 4,
  localparam int CNT_W = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  input  logic [CNT_W-1:0]       num_bytes,
  output logic [MAX_BYTES*8-1:0] word,
  output logic                   word_valid
);

  logic [MAX_BYTES*8-1:0] shift_q;
  logic [MAX_BYTES*8-1:0] gathered;
  logic [CNT_W-1:0]       count_q;
  logic                   last;

  // Bytes enter at the top; a short word is right-aligned, pushing older bytes out.
  assign gathered   = {byte_data, shift_q[MAX_BYTES*8-1:8]};
  assign word       = gathered >> (8 * (MAX_BYTES - int'(num_bytes)));
  assign last       = (count_q == num_bytes - CNT_W'(1));
  assign word_valid = byte_valid & last;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (byte_valid) begin
      shift_q <= gathered;
      count_q <= last ? '0 : count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/boot_image_writer.sv
// rtl/boot_image_writer.sv - SD byte stream to RAM word writer driven by a word-count header
// BOOT_IMAGE_CHECKSUM_EN adds a trailing 32-bit sum check before done.
module boot_image_writer
  import boot_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 20,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 1 << 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sig_write,
  input  logic              m_is_ready,
  output logic              done,
  output logic              error
);

  localparam int WORD_BYTES = DATA_W / 8;
  localparam int PACK_BYTES = max_int(WORD_BYTES, max_int(HDR_BYTES, CSUM_BYTES));
  localparam int CNT_W      = $clog2(PACK_BYTES + 1);
  localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);

`ifdef BOOT_IMAGE_CHECKSUM_EN
  localparam boot_state_t END_STATE = CSUM;
`else
  localparam boot_state_t END_STATE = DONE;
`endif

  boot_state_t             state;
  boot_state_t             state_next;
  logic [31:0]             len_q;
  logic [31:0]             count_q;
  logic [31:0]             count_inc;
  logic                    byte_take;
  logic                    wr_done;
  logic [CNT_W-1:0]        pack_bytes;
  logic [PACK_BYTES*8-1:0] pack_word;
  logic [31:0]             pack_word32;
  logic                    pack_valid;

  assign byte_take   = in_valid & in_ready;
  assign wr_done     = (state == WRITE) & m_is_ready;
  assign count_inc   = count_q + 32'd1;
  assign pack_word32 = pack_word[31:0];

  always_comb begin
    pack_bytes = CNT_W'(HDR_BYTES);
    if (state == DATA) pack_bytes = CNT_W'(WORD_BYTES);
    else if (state == CSUM) pack_bytes = CNT_W'(CSUM_BYTES);
  end

  byte_packer #(
    .MAX_BYTES (PACK_BYTES)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_take),
    .byte_data  (in_data),
    .num_bytes  (pack_bytes),
    .word       (pack_word),
    .word_valid (pack_valid)
  );

`ifdef BOOT_IMAGE_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk) begin
    if (reset) sum_q <= '0;
    else if (wr_done) sum_q <= sum_q + 32'(m_data);
  end
`endif

  always_comb begin
    state_next = state;
    case (state)
      HDR: begin
        if (pack_valid) begin
          if (pack_word32 > MAX_LEN) state_next = ERR;
          else if (pack_word32 == '0) state_next = END_STATE;
          else state_next = DATA;
        end
      end
      DATA: begin
        if (pack_valid) state_next = WRITE;
      end
      WRITE: begin
        if (m_is_ready) state_next = (count_inc == len_q) ? END_STATE : DATA;
      end
`ifdef BOOT_IMAGE_CHECKSUM_EN
      CSUM: begin
        if (pack_valid) state_next = (pack_word32 == sum_q) ? DONE : ERR;
      end
`endif
      default: state_next = state;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HDR;
      in_ready    <= 1'b0;
      m_sig_write <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_next;
      in_ready    <= (state_next == HDR) || (state_next == DATA) || (state_next == CSUM);
      m_sig_write <= (state_next == WRITE);
      done        <= (state_next == DONE);
      error       <= (state_next == ERR);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q   <= '0;
      count_q <= '0;
      m_addr  <= BASE_ADDR;
      m_data  <= '0;
    end else begin
      if ((state == HDR) && pack_valid) len_q <= pack_word32;
      if ((state == DATA) && pack_valid) m_data <= pack_word[DATA_W-1:0];
      if (wr_done) begin
        m_addr  <= m_addr + ADDR_W'(1);
        count_q <= count_inc;
      end
    end
  end

endmodule
